// File: rtl/sar_avg_buffer_if.sv
// sar_avg_buffer_if -- signal bundle between the SAR averaging buffer, the
// upstream SAR controller and the downstream sample consumer.
//   enable      : run request (continuous conversion sequencing while high)
//   go          : conversion request to the SAR controller
//   conv_valid  : SAR result valid, held high until go falls
//   conv_result : 8-bit SAR result, stable while conv_valid is high
//   out_data    : averaged word at FIFO head
//   out_valid   : FIFO non-empty
//   out_ready   : consumer accepts out_data when out_valid && out_ready
//   fifo_count  : FIFO occupancy
//   overflow    : sticky, an averaged word was dropped on a full FIFO
// master: the averaging buffer. slave: its environment (SAR + consumer).
interface sar_avg_buffer_if;
  logic       enable;
  logic       go;
  logic       conv_valid;
  logic [7:0] conv_result;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] fifo_count;
  logic       overflow;

  modport master (
    input  enable, conv_valid, conv_result, out_ready,
    output go, out_data, out_valid, fifo_count, overflow
  );

  modport slave (
    output enable, conv_valid, conv_result, out_ready,
    input  go, out_data, out_valid, fifo_count, overflow
  );
endinterface

// File: rtl/sar_avg_buffer.sv
// sar_avg_buffer -- sequences an external SAR converter, averages
// 2^AVG_LOG2 conversion results per output word and queues the averaged
// words in a small FIFO for a ready/valid consumer.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sar_avg_buffer_if.master (SAR handshake + FIFO output side)
// Parameters:
//   AVG_LOG2   : log2 of conversions per output word, 0..4
//   FIFO_DEPTH : FIFO entries, power of two, 2..16
// Build option:
//   SAR_AVG_ROUND_EN : when defined, round half up before the averaging
//                      shift; otherwise truncate.
module sar_avg_buffer #(
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sar_avg_buffer_if.master bus
);

  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REARM   = 2'd1,
    CONV    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             last_sample;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_rnd;
  logic [7:0]       avg_word;

  // Accumulator including the sample being captured this cycle; the width
  // holds 2^AVG_LOG2 full-scale samples, so it never wraps.
  assign acc_sum     = acc_q + ACC_W'(bus.conv_result);
  assign last_sample = (cnt_q == CNT_W'((1 << AVG_LOG2) - 1));

`ifdef SAR_AVG_ROUND_EN
  generate
    if (AVG_LOG2 > 0) begin : g_round
      // Half an LSB of the result; the sum still fits in ACC_W bits.
      assign acc_rnd = acc_sum + ACC_W'(1 << (AVG_LOG2 - 1));
    end else begin : g_pass
      assign acc_rnd = acc_sum;
    end
  endgenerate
`else
  assign acc_rnd = acc_sum;
`endif

  assign avg_word = 8'(acc_rnd >> AVG_LOG2);

  // Sequencer: REARM holds go low one cycle so the SAR returns to its wait
  // state before the next request.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = REARM;
      end
      REARM: begin
        state_d = CONV;
      end
      CONV: begin
        if (!bus.enable) begin
          // Abandoning the run throws away a partial average.
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (bus.conv_valid) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = bus.enable ? REARM : IDLE;
        if (last_sample) begin
          push  = 1'b1;
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.go = (state_q == CONV) || (state_q == CAPTURE);

  // FIFO: a pop in the same cycle frees the slot, so a push onto a full
  // FIFO only drops when nothing is popped.
  assign full  = (count_q == 5'(FIFO_DEPTH));
  assign pop   = (count_q != 5'd0) && bus.out_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {4'd0, wr_en} - {4'd0, pop};
    overflow_d = overflow_q | (push && full && !pop);
    // Pointers are log2(depth) wide, so the increment wraps by itself.
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: an entry is only visible once written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= avg_word;
  end

  assign bus.out_data   = mem_q[rd_ptr_q];
  assign bus.out_valid  = (count_q != 5'd0);
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_sar_avg_buffer.sv
// tb_sar_avg_buffer -- randomized bench for sar_avg_buffer. Two instances
// share the SAR responder and enable: dut_a averages 4 samples, dut_b
// (AVG_LOG2=0) passes every result through. A transaction-level model
// (sample lists, queues) predicts FIFO contents, occupancy and overflow.
`timescale 1ns/1ps
module tb_sar_avg_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       enable = 1'b0;
  logic       ready_a = 1'b0;
  logic       ready_b = 1'b0;
  logic       cv;
  logic [7:0] res;
  int         delay;
  logic [7:0] res_q [$];

  sar_avg_buffer_if bus_a ();
  sar_avg_buffer_if bus_b ();

  assign bus_a.enable      = enable;
  assign bus_a.conv_valid  = cv;
  assign bus_a.conv_result = res;
  assign bus_a.out_ready   = ready_a;
  assign bus_b.enable      = enable;
  assign bus_b.conv_valid  = cv;
  assign bus_b.conv_result = res;
  assign bus_b.out_ready   = ready_b;

  sar_avg_buffer #(.AVG_LOG2(2), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  sar_avg_buffer #(.AVG_LOG2(0), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master));

  // SAR controller stand-in: answers go after 0..3 cycles, drops valid when go falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv    <= 1'b0;
      res   <= 8'd0;
      delay <= 0;
    end else if (!bus_a.go) begin
      cv    <= 1'b0;
      delay <= int'($urandom_range(0, 3));
    end else if (!cv) begin
      if (delay == 0) begin
        cv <= 1'b1;
        if (res_q.size() > 0) res <= res_q.pop_front();
        else                  res <= 8'($urandom);
      end else begin
        delay <= delay - 1;
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] ea_q [$];
  logic [7:0] eb_q [$];
  logic       go_exp [$];
  logic       eovf_a, eovf_b;
  int         psum, pcnt, gv_run, n_caps;
  logic       s_rst, s_go, s_cv, s_en, s_rdy_a, s_rdy_b;
  logic [7:0] s_res;

  function automatic logic [7:0] avg4(input int sum);
`ifdef SAR_AVG_ROUND_EN
    return 8'((sum + 2) / 4);
`else
    return 8'(sum / 4);
`endif
  endfunction

  task automatic model_clear();
    ea_q.delete(); eb_q.delete(); go_exp.delete();
    eovf_a = 1'b0; eovf_b = 1'b0;
    psum = 0; pcnt = 0; gv_run = 0; n_caps = 0;
  endtask

  task automatic model_step();
    bit cap, push_a;
    logic [7:0] wa;
    cap = 1'b0; push_a = 1'b0; wa = 8'd0;
    // A result is taken on the second consecutive cycle with go and valid.
    if (s_go && s_cv) begin
      cap = (gv_run == 1);
      gv_run++;
    end else begin
      gv_run = 0;
    end
    if (s_go && !s_cv && !s_en) begin
      psum = 0; pcnt = 0;
      go_exp.push_back(1'b0);
    end
    if (cap) begin
      n_caps++;
      psum += int'(s_res);
      pcnt++;
      if (pcnt == 4) begin
        push_a = 1'b1; wa = avg4(psum); psum = 0; pcnt = 0;
      end
      go_exp.push_back(1'b0);
      if (s_en) go_exp.push_back(1'b1);
    end
    if (ea_q.size() > 0 && s_rdy_a) begin
      $display("pop a: word=%0d", ea_q[0]);
      void'(ea_q.pop_front());
    end
    if (push_a) begin
      if (ea_q.size() < DEPTH) ea_q.push_back(wa);
      else                     eovf_a = 1'b1;
    end
    if (eb_q.size() > 0 && s_rdy_b) void'(eb_q.pop_front());
    if (cap) begin
      if (eb_q.size() < DEPTH) eb_q.push_back(s_res);
      else                     eovf_b = 1'b1;
    end
  endtask

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) model_clear();
      chk("a_valid", int'(bus_a.out_valid), int'(ea_q.size() > 0));
      chk("a_count", int'(bus_a.fifo_count), ea_q.size());
      chk("a_ovf", int'(bus_a.overflow), int'(eovf_a));
      if (ea_q.size() > 0) chk("a_data", int'(bus_a.out_data), int'(ea_q[0]));
      chk("b_count", int'(bus_b.fifo_count), eb_q.size());
      chk("b_ovf", int'(bus_b.overflow), int'(eovf_b));
      if (eb_q.size() > 0) chk("b_data", int'(bus_b.out_data), int'(eb_q[0]));
      if (go_exp.size() > 0) chk("go_seq", int'(bus_a.go), int'(go_exp.pop_front()));
      s_rst = rst_n; s_go = bus_a.go; s_cv = cv; s_en = enable;
      s_res = res; s_rdy_a = ready_a; s_rdy_b = ready_b;
      @(posedge clk);
      if (s_rst && rst_n) model_step();
    end
  end

  // ---------------- stimulus ----------------
  int target;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int id);
    case (id)
      0: return bus_a.out_valid;
      1: return n_caps >= target;
      2: return bus_a.go && !cv;
      3: return (gv_run == 1) && bus_a.go && cv;
      4: return bus_b.fifo_count == 5'd3;
      default: return !cv;
    endcase
  endfunction

  task automatic wait_for(input int id, input string name);
    int k;
    k = 0;
    while (!cond(id) && k < 400) begin
      tick(1);
      k++;
    end
    chk({"wait_", name}, int'(cond(id)), 1);
  endtask

  // Never lower enable while a result is pending in CONV.
  task automatic drop_enable();
    wait_for(5, "cv_low");
    enable = 1'b0;
    tick(3);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    res_q.delete();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int rdy_pct;
    #1;
    tick(2);
    chk("rst_go", int'(bus_a.go), 0);
    chk("rst_valid", int'(bus_a.out_valid), 0);
    chk("rst_count", int'(bus_a.fifo_count), 0);
    chk("rst_ovf", int'(bus_a.overflow), 0);
    rst_n = 1'b1;
    tick(1);

    // Average of 10,11,12,14 = 11.75.
    res_q = '{8'd10, 8'd11, 8'd12, 8'd14};
    enable = 1'b1;
    wait_for(0, "avg_valid");
`ifdef SAR_AVG_ROUND_EN
    chk("avg_10_14", int'(bus_a.out_data), 12);
`else
    chk("avg_10_14", int'(bus_a.out_data), 11);
`endif
    // Word appears the cycle after the 4th capture, same edge b holds 4 results.
    chk("avg_latency", int'(bus_b.fifo_count), 4);
    chk("pass_head", int'(bus_b.out_data), 10);
    drop_enable();

    // Full scale never overflows the accumulator.
    do_reset();
    res_q = '{8'd255, 8'd255, 8'd255, 8'd255};
    enable = 1'b1;
    wait_for(0, "max_valid");
    chk("avg_255", int'(bus_a.out_data), 255);
    drop_enable();

    // Five results into a 4-deep pass-through FIFO with no consumer.
    do_reset();
    res_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    target = 5;
    enable = 1'b1;
    wait_for(1, "five_caps");
    chk("ovf_set", int'(bus_b.overflow), 1);
    drop_enable();
    chk("ovf_count", int'(bus_b.fifo_count), 4);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_order", int'(bus_b.out_data), k);
      ready_b = 1'b1;
      tick(1);
      ready_b = 1'b0;
    end
    chk("ovf_sticky", int'(bus_b.overflow), 1);

    // Full FIFO, pop on the push cycle: nothing dropped.
    do_reset();
    res_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    target = 4;
    enable = 1'b1;
    wait_for(1, "four_caps");
    wait_for(3, "fifth_cap");
    ready_b = 1'b1;
    tick(1);
    ready_b = 1'b0;
    chk("pp_count", int'(bus_b.fifo_count), 4);
    chk("pp_ovf", int'(bus_b.overflow), 0);
    chk("pp_head", int'(bus_b.out_data), 2);
    drop_enable();

    // Abort in CONV after two samples discards them.
    do_reset();
    res_q = '{8'd99, 8'd77, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20};
    target = 2;
    enable = 1'b1;
    wait_for(1, "two_caps");
    wait_for(2, "in_conv");
    enable = 1'b0;
    tick(1);
    chk("abort_go", int'(bus_a.go), 0);
    tick(2);
    enable = 1'b1;
    wait_for(0, "abort_valid");
    chk("abort_word", int'(bus_a.out_data), 20);
    drop_enable();

    // Asynchronous reset mid-conversion with words queued.
    do_reset();
    enable = 1'b1;
    wait_for(4, "three_words");
    wait_for(2, "conv_again");
    rst_n = 1'b0;
    #1;
    chk("arst_go", int'(bus_a.go), 0);
    chk("arst_valid", int'(bus_b.out_valid), 0);
    chk("arst_count", int'(bus_b.fifo_count), 0);
    chk("arst_ovf", int'(bus_b.overflow), 0);
    tick(2);
    rst_n = 1'b1;
    enable = 1'b0;
    tick(1);

    // Randomized traffic.
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) rdy_pct = int'($urandom_range(0, 100));
      if (enable) begin
        if (!cv && $urandom_range(0, 99) < 3) enable = 1'b0;
      end else if ($urandom_range(0, 99) < 30) begin
        enable = 1'b1;
      end
      ready_a = ($urandom_range(0, 99) < rdy_pct);
      ready_b = ($urandom_range(0, 99) < rdy_pct);
      if (i == 1500) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
